led_panel_sink: RTL and testbench

LED_PANEL_SINK -- requirements
Module: led_panel_sink

---
 rtl/led_panel_pkg.sv | 29 ++
 rtl/led_panel_sink_fb.sv | 55 +++++
 rtl/led_panel_sink.sv | 230 +++++++++++++++++++++++
 tb/tb_led_panel_sink.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
//
// Shared definitions for the LED panel sink: default geometry, the colour
// triple type, the capture FSM state encoding and a small edge helper.
// Imported by led_panel_sink and led_panel_sink_fb.
// -----------------------------------------------------------------------------
package led_panel_pkg;

    // Default panel geometry: columns per latch and row addresses per scan.
    localparam int DEF_NCOLS = 32;
    localparam int DEF_NROWS = 4;

    // One panel pixel, ordered {r, g, b}.
    typedef logic [2:0] rgb_t;

    // Capture FSM: waiting for data, shifting a row in, writing it to the frame.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } sink_state_t;

    // Rising edge of a level signal given its one-cycle-old copy.
    function automatic logic rise(input logic prev, input logic cur);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/led_panel_sink_fb.sv
// -----------------------------------------------------------------------------
// led_panel_sink_fb
//
// Frame store for the LED panel sink. One whole row (NCOLS pixels) is written
// per commit; a single pixel is read back with one cycle of latency. A read
// and a write to the same row in the same cycle return the old contents.
//
// Ports
//   clk      in   clock, all logic on posedge
//   reset    in   synchronous active-high reset, clears the whole frame
//   wr_en    in   write the full row wr_data into row wr_row
//   wr_row   in   row index for the write
//   wr_data  in   NCOLS pixels, element k is column k
//   rd_row   in   row index for the read
//   rd_col   in   column index for the read
//   rd_rgb   out  registered pixel {r,g,b} at rd_row/rd_col
// -----------------------------------------------------------------------------
module led_panel_sink_fb
    import led_panel_pkg::*;
#(
    parameter int NCOLS = DEF_NCOLS,
    parameter int NROWS = DEF_NROWS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(NROWS)-1:0] wr_row,
    input  logic [NCOLS-1:0][2:0]    wr_data,
    input  logic [$clog2(NROWS)-1:0] rd_row,
    input  logic [$clog2(NCOLS)-1:0] rd_col,
    output rgb_t                     rd_rgb
);

    logic [NCOLS-1:0][2:0] mem [NROWS];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the frame must read back as all-zero after reset, so the
            // store is built from resettable flops rather than a RAM macro
            // (RAM arrays cannot be cleared in one cycle).
            for (int r = 0; r < NROWS; r++) begin
                mem[r] <= '0;
            end
            rd_rgb <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_row] <= wr_data;
            end
            // Reads sample the array before this edge's write lands, which
            // gives pre-commit data on a same-cycle collision.
            rd_rgb <= mem[rd_row][rd_col];
        end
    end

endmodule

// File: rtl/led_panel_sink.sv
// -----------------------------------------------------------------------------
// led_panel_sink
//
// Behavioural sink for a HUB-style LED panel bus. Colour bits are clocked into
// an NCOLS-long shift register on each rising edge of sclk_in, the register is
// committed into a frame store row on a rising edge of latch_in, and the row
// address follows aclk_in / arst_in. The frame is read back one pixel at a
// time through rd_row/rd_col/rd_rgb.
//
// All panel inputs are already synchronous to clk. Each one is registered once
// and an edge is "previous copy 0, current input 1". The shifted colour is the
// registered copy, i.e. the colour present the cycle before the sclk edge.
//
// Optional feature: define LED_PANEL_SINK_ERR_EN to build the shift counter and
// the sticky err_overrun / err_underrun flags. Without it both flags are 0.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   red_in        in   panel red data
//   green_in      in   panel green data
//   blue_in       in   panel blue data
//   sclk_in       in   panel shift clock
//   latch_in      in   latch strobe, active-high
//   blank_in      in   output blank, active-high (only used by error checks)
//   aclk_in       in   row-address advance
//   arst_in       in   row-address reset, active-high, wins over aclk_in
//   rd_row        in   frame read row
//   rd_col        in   frame read column
//   rd_rgb        out  {r,g,b} at rd_row/rd_col, one cycle latency
//   row_valid     out  one-cycle pulse the cycle after a row is committed
//   frame_done    out  one-cycle pulse when the row address wraps to 0
//   err_overrun   out  sticky: a commit saw more than NCOLS shifts
//   err_underrun  out  sticky: a commit saw fewer than NCOLS shifts, or data
//                      was shifted while the panel was not blanked
// -----------------------------------------------------------------------------
module led_panel_sink
    import led_panel_pkg::*;
#(
    parameter int NCOLS = DEF_NCOLS,
    parameter int NROWS = DEF_NROWS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     red_in,
    input  logic                     green_in,
    input  logic                     blue_in,
    input  logic                     sclk_in,
    input  logic                     latch_in,
    input  logic                     blank_in,
    input  logic                     aclk_in,
    input  logic                     arst_in,
    input  logic [$clog2(NROWS)-1:0] rd_row,
    input  logic [$clog2(NCOLS)-1:0] rd_col,
    output logic [2:0]               rd_rgb,
    output logic                     row_valid,
    output logic                     frame_done,
    output logic                     err_overrun,
    output logic                     err_underrun
);

    localparam int RW = $clog2(NROWS);

    // ------------------------------------------------------------------
    // Input copies and edge detection
    // ------------------------------------------------------------------
    logic        sclk_prev;
    logic        latch_prev;
    logic        aclk_prev;
    rgb_t        rgb_prev;
    logic        sclk_rise;
    logic        latch_rise;
    logic        aclk_rise;

    always_ff @(posedge clk) begin
        // NOTE: every register in this design is assigned with <= so all
        // flops sample the same pre-edge values; a blocking = here would let
        // later statements see the new value and skew the edge detectors.
        if (reset) begin
            sclk_prev  <= 1'b0;
            latch_prev <= 1'b0;
            aclk_prev  <= 1'b0;
            rgb_prev   <= '0;
        end else begin
            sclk_prev  <= sclk_in;
            latch_prev <= latch_in;
            aclk_prev  <= aclk_in;
            rgb_prev   <= {red_in, green_in, blue_in};
        end
    end

    assign sclk_rise  = rise(sclk_prev,  sclk_in);
    assign latch_rise = rise(latch_prev, latch_in);
    assign aclk_rise  = rise(aclk_prev,  aclk_in);

    // ------------------------------------------------------------------
    // Column shift register: element 0 is the newest column.
    // ------------------------------------------------------------------
    logic [NCOLS-1:0][2:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else if (sclk_rise) begin
            shift_q <= {shift_q[NCOLS-2:0], rgb_prev};
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM. The commit happens in the cycle after the latch edge,
    // so a shift coinciding with the latch edge is already in shift_q by
    // the time the row is written.
    // ------------------------------------------------------------------
    sink_state_t state_q;
    logic        commit_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_valid <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (latch_rise) begin
                        state_q <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (latch_rise) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state_q   <= ST_IDLE;
                    row_valid <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign commit_en = (state_q == ST_COMMIT);

    // ------------------------------------------------------------------
    // Row address and frame wrap pulse. arst_in is level-sensitive and
    // overrides an aclk edge in the same cycle.
    // ------------------------------------------------------------------
    logic [RW-1:0] row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (arst_in) begin
                row_q      <= '0;
                frame_done <= (row_q != '0);
            end else if (aclk_rise) begin
                // NROWS is a power of two, so the natural wrap is modulo NROWS.
                row_q      <= row_q + 1'b1;
                frame_done <= (row_q == RW'(NROWS - 1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame store
    // ------------------------------------------------------------------
    led_panel_sink_fb #(
        .NCOLS (NCOLS),
        .NROWS (NROWS)
    ) u_fb (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit_en),
        .wr_row  (row_q),
        .wr_data (shift_q),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_rgb  (rd_rgb)
    );

    // ------------------------------------------------------------------
    // Optional protocol error checking
    // ------------------------------------------------------------------
`ifdef LED_PANEL_SINK_ERR_EN
    localparam int              CNTW     = $clog2(NCOLS + 2);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(NCOLS + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NCOLS);

    // Shifts since the last commit; saturating at NCOLS+1 is enough to tell
    // "too many" from "exactly right".
    logic [CNTW-1:0] shift_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt    <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            // A shift landing in the commit cycle belongs to the next row.
            if (commit_en) begin
                shift_cnt <= CNTW'(sclk_rise);
            end else if (sclk_rise && (shift_cnt != CNT_SAT)) begin
                shift_cnt <= shift_cnt + 1'b1;
            end

            if (commit_en && (shift_cnt > CNT_FULL)) begin
                err_overrun <= 1'b1;
            end
            // Shifting into an unblanked panel shows partial data.
            if ((commit_en && (shift_cnt < CNT_FULL)) || (sclk_rise && !blank_in)) begin
                err_underrun <= 1'b1;
            end
        end
    end
`else
    // blank_in has no effect when error checking is not built.
    logic unused_blank;
    assign unused_blank = blank_in;

    assign err_overrun  = 1'b0;
    assign err_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_led_panel_sink.sv
// -----------------------------------------------------------------------------
// tb_led_panel_sink
//
// Scoreboard bench for led_panel_sink. Stimulus tasks drive the panel bus and
// update a queue/array model of the panel (shift queue, frame array, row
// address, error flags); expected responses are pushed into queues and popped
// by independent monitors on rd_rgb, row_valid and frame_done.
// Build with LED_PANEL_SINK_ERR_EN defined to also expect the error flags.
// -----------------------------------------------------------------------------
module tb_led_panel_sink;
    import led_panel_pkg::*;

    localparam int NCOLS = DEF_NCOLS;
    localparam int NROWS = DEF_NROWS;
    localparam int RW    = $clog2(NROWS);
    localparam int CW    = $clog2(NCOLS);
`ifdef LED_PANEL_SINK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
    logic          sclk_in = 1'b0, latch_in = 1'b0, blank_in = 1'b1;
    logic          aclk_in = 1'b0, arst_in = 1'b0;
    logic [RW-1:0] rd_row = '0;
    logic [CW-1:0] rd_col = '0;
    logic [2:0]    rd_rgb;
    logic          row_valid, frame_done, err_overrun, err_underrun;

    led_panel_sink #(.NCOLS(NCOLS), .NROWS(NROWS)) dut (
        .clk          (clk),
        .reset        (reset),
        .red_in       (red_in),
        .green_in     (green_in),
        .blue_in      (blue_in),
        .sclk_in      (sclk_in),
        .latch_in     (latch_in),
        .blank_in     (blank_in),
        .aclk_in      (aclk_in),
        .arst_in      (arst_in),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_rgb       (rd_rgb),
        .row_valid    (row_valid),
        .frame_done   (frame_done),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an event with nothing expected", name);
    endtask

    // ---------------- reference model ----------------
    logic [2:0] m_sr[$];                 // index k = column k
    logic [2:0] m_fb [NROWS][NCOLS];
    int         m_row;
    int         m_cnt;
    bit         m_ovr, m_und;

    task automatic model_reset();
        m_sr.delete();
        for (int c = 0; c < NCOLS; c++) m_sr.push_back(3'b000);
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++) m_fb[r][c] = 3'b000;
        m_row = 0;
        m_cnt = 0;
        m_ovr = 1'b0;
        m_und = 1'b0;
    endtask

    task automatic model_commit();
        for (int c = 0; c < NCOLS; c++) m_fb[m_row][c] = m_sr[c];
        if (ERR_EN) begin
            if (m_cnt > NCOLS) m_ovr = 1'b1;
            if (m_cnt < NCOLS) m_und = 1'b1;
        end
        m_cnt = 0;
    endtask

    // ---------------- scoreboards ----------------
    typedef struct { int cyc; bit ovr; bit und; } rv_exp_t;
    typedef struct { int row; int col; logic [2:0] rgb; } rd_exp_t;

    rv_exp_t rv_q[$];
    int      fd_q[$];
    rd_exp_t rd_q[$];
    logic    rd_pend = 1'b0;
    logic    rd_fire = 1'b0;

    task automatic push_rv(input int c);
        rv_exp_t e;
        e.cyc = c;
        e.ovr = m_ovr;
        e.und = m_und;
        rv_q.push_back(e);
    endtask

    always @(posedge clk) rd_fire <= rd_pend;

    always @(negedge clk) begin : mon_rd
        rd_exp_t e;
        if (rd_fire) begin
            if (rd_q.size() == 0) fail("rd_rgb");
            else begin
                e = rd_q.pop_front();
                check($sformatf("rd_rgb[%0d][%0d]", e.row, e.col), 32'(rd_rgb), 32'(e.rgb));
            end
        end
    end

    always @(negedge clk) begin : mon_rv
        rv_exp_t e;
        if (row_valid) begin
            if (rv_q.size() == 0) fail("row_valid");
            else begin
                e = rv_q.pop_front();
                check("row_valid cycle", cyc, e.cyc);
                check("err_overrun at commit", 32'(err_overrun), 32'(e.ovr));
                check("err_underrun at commit", 32'(err_underrun), 32'(e.und));
            end
        end else if (rv_q.size() != 0 && rv_q[0].cyc <= cyc) begin
            e = rv_q.pop_front();
            check("row_valid missing at cycle", cyc + 1, e.cyc);
        end
    end

    always @(negedge clk) begin : mon_fd
        int e;
        if (frame_done) begin
            if (fd_q.size() == 0) fail("frame_done");
            else begin
                e = fd_q.pop_front();
                check("frame_done cycle", cyc, e);
            end
        end else if (fd_q.size() != 0 && fd_q[0] <= cyc) begin
            e = fd_q.pop_front();
            check("frame_done missing at cycle", cyc + 1, e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {red_in, green_in, blue_in} = 3'b000;
        sclk_in = 1'b0; latch_in = 1'b0; blank_in = 1'b1;
        aclk_in = 1'b0; arst_in = 1'b0;
        rd_row = '0; rd_col = '0; rd_pend = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One sclk pulse: colour held through the low and high phases.
    task automatic shift(input logic [2:0] rgb, input bit blank, input bit with_latch);
        {red_in, green_in, blue_in} = rgb;
        blank_in = blank;
        tick();
        sclk_in = 1'b1;
        m_sr.push_front(rgb);
        void'(m_sr.pop_back());
        m_cnt++;
        if (ERR_EN && !blank) m_und = 1'b1;
        if (with_latch) begin
            latch_in = 1'b1;
            model_commit();
            push_rv(cyc + 2);
        end
        tick();
        sclk_in = 1'b0;
        latch_in = 1'b0;
        blank_in = 1'b1;
        if (with_latch) begin
            tick();
            tick();
        end
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift(3'($urandom_range(0, 7)), 1'b1, 1'b0);
    endtask

    task automatic latch();
        latch_in = 1'b1;
        model_commit();
        push_rv(cyc + 2);
        tick();
        latch_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic aclk_pulse(input bit with_arst);
        aclk_in = 1'b1;
        arst_in = with_arst;
        if (with_arst) begin
            if (m_row != 0) fd_q.push_back(cyc + 1);
            m_row = 0;
        end else begin
            m_row = (m_row + 1) % NROWS;
            if (m_row == 0) fd_q.push_back(cyc + 1);
        end
        tick();
        aclk_in = 1'b0;
        arst_in = 1'b0;
        tick();
    endtask

    task automatic arst_pulse();
        arst_in = 1'b1;
        if (m_row != 0) fd_q.push_back(cyc + 1);
        m_row = 0;
        tick();
        arst_in = 1'b0;
        tick();
    endtask

    task automatic rd(input int r, input int c);
        rd_exp_t e;
        rd_row = RW'(r);
        rd_col = CW'(c);
        e.row = r;
        e.col = c;
        e.rgb = m_fb[r][c];
        rd_q.push_back(e);
        rd_pend = 1'b1;
        tick();
        rd_pend = 1'b0;
    endtask

    task automatic read_row(input int r);
        for (int c = 0; c < NCOLS; c++) rd(r, c);
    endtask

    task automatic read_all();
        for (int r = 0; r < NROWS; r++) read_row(r);
    endtask

    task automatic check_static(input string tag, input bit with_rd);
        @(negedge clk);
        check({tag, " row_valid"}, 32'(row_valid), 32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " err_overrun"}, 32'(err_overrun), 32'(m_ovr));
        check({tag, " err_underrun"}, 32'(err_underrun), 32'(m_und));
        if (with_rd) check({tag, " rd_rgb"}, 32'(rd_rgb), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check_static("after reset", 1'b1);
        rd(0, 0);
        rd(NROWS - 1, NCOLS - 1);

        // Single marked pixel walks to the far column
        for (int i = 0; i < NCOLS; i++) shift((i == 0) ? 3'b101 : 3'b000, 1'b1, 1'b0);
        latch();
        read_row(0);

        // Full frame, wrap on the last aclk
        arst_pulse();
        for (int r = 0; r < NROWS; r++) begin
            shift_rand(NCOLS);
            latch();
            aclk_pulse(1'b0);
        end
        read_all();

        // aclk and arst together at row 2: arst wins
        aclk_pulse(1'b0);
        aclk_pulse(1'b0);
        aclk_pulse(1'b1);
        shift_rand(NCOLS);
        latch();
        read_row(0);
        read_row(2);

        // Latch edge coincides with the last shift
        shift_rand(NCOLS - 1);
        shift(3'b110, 1'b1, 1'b1);
        rd(0, 0);
        rd(0, 1);
        rd(0, NCOLS - 1);

        // Randomised rows
        for (int k = 0; k < 6; k++) begin
            int n_adv;
            n_adv = $urandom_range(0, 2);
            for (int a = 0; a < n_adv; a++) aclk_pulse(1'b0);
            shift_rand(NCOLS);
            latch();
            for (int j = 0; j < 8; j++) rd($urandom_range(0, NROWS - 1), $urandom_range(0, NCOLS - 1));
        end
        check_static("after random rows", 1'b0);

        // Reset mid-row discards partial data
        shift_rand(10);
        do_reset();
        check_static("mid-row reset", 1'b1);
        shift_rand(NCOLS);
        latch();
        read_all();
        check_static("post-reset row", 1'b0);

        // Overrun, sticky
        do_reset();
        shift_rand(NCOLS + 1);
        latch();
        check_static("overrun", 1'b0);
        shift_rand(NCOLS);
        latch();
        check_static("overrun sticky", 1'b0);

        // Underrun by short row, sticky
        do_reset();
        check_static("cleared", 1'b1);
        shift_rand(NCOLS - 1);
        latch();
        check_static("underrun", 1'b0);
        repeat (3) tick();
        check_static("underrun sticky", 1'b0);

        // Underrun by shifting while not blanked
        do_reset();
        shift_rand(5);
        shift(3'b111, 1'b0, 1'b0);
        shift_rand(NCOLS - 6);
        latch();
        check_static("unblanked shift", 1'b0);
        read_row(0);

        do_reset();
        check_static("final reset", 1'b1);

        repeat (5) tick();
        check("row_valid queue drained", rv_q.size(), 0);
        check("frame_done queue drained", fd_q.size(), 0);
        check("rd queue drained", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
